// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station; holds instructions until operands arrive, dispatches one per cycle.
// Optional macro RS_LSB_CDB_EN adds a second (load/store buffer) broadcast bus for wakeup.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int RS_SIZE_WIDTH = 3,
  parameter int ROB_SIZE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      rob_clear,
  input  logic                      issue_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic [4:0]                issue_op,
  input  logic [31:0]               issue_v1,
  input  logic [31:0]               issue_v2,
  input  logic                      issue_q1_wait,
  input  logic                      issue_q2_wait,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_q1,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_q2,
  input  logic                      cdb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id,
  input  logic [31:0]               cdb_result,
`ifdef RS_LSB_CDB_EN
  input  logic                      lsb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]               lsb_result,
`endif
  output logic                      rs_full,
  output logic                      alu_valid,
  output logic [ROB_SIZE_WIDTH-1:0] alu_rob_id,
  output logic [4:0]                alu_op,
  output logic [31:0]               alu_v1,
  output logic [31:0]               alu_v2
);
  logic [RS_SIZE-1:0] busy, w1, w2;
  logic [ROB_SIZE_WIDTH-1:0] rid [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] q1 [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] q2 [RS_SIZE];
  logic [4:0] op [RS_SIZE];
  logic [31:0] v1 [RS_SIZE];
  logic [31:0] v2 [RS_SIZE];
  logic [RS_SIZE_WIDTH-1:0] free_idx, sel_idx;
  logic sel_found;

  // Returns {wait, value} after snooping the broadcast bus(es); the ALU CDB has priority.
  function automatic logic [32:0] snoop(input logic w, input logic [ROB_SIZE_WIDTH-1:0] q,
                                        input logic [31:0] v);
`ifdef RS_LSB_CDB_EN
    return (w && cdb_ready && cdb_rob_id == q) ? {1'b0, cdb_result} :
           (w && lsb_ready && lsb_rob_id == q) ? {1'b0, lsb_result} : {w, v};
`else
    return (w && cdb_ready && cdb_rob_id == q) ? {1'b0, cdb_result} : {w, v};
`endif
  endfunction

  assign rs_full = &busy;

  always_comb begin
    free_idx = '0;
    sel_idx = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = RS_SIZE_WIDTH'(i);
      if (busy[i] && !w1[i] && !w2[i]) begin
        sel_idx = RS_SIZE_WIDTH'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      alu_valid <= 1'b0;
      alu_rob_id <= '0;
      alu_op <= '0;
      alu_v1 <= '0;
      alu_v2 <= '0;
    end else if (rdy) begin
      if (rob_clear) begin
        busy <= '0;
        alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            {w1[i], v1[i]} <= snoop(w1[i], q1[i], v1[i]);
            {w2[i], v2[i]} <= snoop(w2[i], q2[i], v2[i]);
          end
        end
        alu_valid <= sel_found;
        if (sel_found) begin
          alu_rob_id <= rid[sel_idx];
          alu_op <= op[sel_idx];
          alu_v1 <= v1[sel_idx];
          alu_v2 <= v2[sel_idx];
          busy[sel_idx] <= 1'b0;
        end
        // Free slot is chosen from pre-edge busy bits, so it never collides with the dispatched one.
        if (issue_valid && !rs_full) begin
          busy[free_idx] <= 1'b1;
          rid[free_idx] <= issue_rob_id;
          op[free_idx] <= issue_op;
          q1[free_idx] <= issue_q1;
          q2[free_idx] <= issue_q2;
          {w1[free_idx], v1[free_idx]} <= snoop(issue_q1_wait, issue_q1, issue_v1);
          {w2[free_idx], v2[free_idx]} <= snoop(issue_q2_wait, issue_q2, issue_v2);
        end
      end
    end
  end
endmodule
